// File: rtl/serializer.sv
// ---------------------------------------------------------------------------
// serializer
//   Parallel-to-serial transmitter for the cipher's 1-bit serial link.
//   A word is captured on an accepted start and shifted out MSB first,
//   one bit per iEn strobe, while oLoading is high. A deserializer running
//   on the same iClk/iEn and fed by oData_out/oLoading rebuilds the word.
//
//   Optional feature macro: SERIALIZER_PARITY_EN
//     defined   -> an even-parity bit (XOR of the word) follows the data bits
//     undefined -> exactly DATA_SIZE bits are sent, no parity logic
//
// Ports
//   iClk          clock, rising edge
//   iRst          asynchronous reset, active low
//   iEn           bit strobe; one serial bit is consumed per cycle with iEn=1
//   iStart        send request, honoured only in IDLE
//   iData         parallel word, sampled on the accepted start cycle
//   oData_out     serial bit, valid while oLoading=1
//   oLoading      high while serial bits are being presented
//   oBusy         high from start acceptance until return to IDLE
//   oDone         one-cycle pulse once the last bit has been consumed
//   oBit_counter  bits consumed in the current/last word
// ---------------------------------------------------------------------------
module serializer #(
    parameter int DATA_SIZE = 32
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iEn,
    input  logic                       iStart,
    input  logic [DATA_SIZE-1:0]       iData,
    output logic                       oData_out,
    output logic                       oLoading,
    output logic                       oBusy,
    output logic                       oDone,
    output logic [$clog2(DATA_SIZE):0] oBit_counter
);

    localparam int CW = $clog2(DATA_SIZE) + 1;
`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = DATA_SIZE + 1;
`else
    localparam int NBITS = DATA_SIZE;
`endif
    localparam logic [CW-1:0] LAST = CW'(NBITS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    // The bit currently on oData_out sits at the MSB of shreg; the parity
    // bit (when enabled) is appended at the LSB so it simply shifts out last.
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] loadWord;
    logic [CW-1:0]    cntNext;

    always_comb begin
        loadWord = '0;
`ifdef SERIALIZER_PARITY_EN
        loadWord = {iData, ^iData};
`else
        loadWord = iData;
`endif
    end

    assign cntNext = oBit_counter + 1'b1;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state        <= IDLE;
            shreg        <= '0;
            oData_out    <= 1'b0;
            oLoading     <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oBit_counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        shreg        <= loadWord;
                        oBit_counter <= '0;
                        oData_out    <= loadWord[NBITS-1];
                        oLoading     <= 1'b1;
                        oBusy        <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    // iEn=0 holds everything, so the bit stays stable.
                    if (iEn) begin
                        oBit_counter <= cntNext;
                        if (cntNext == LAST) begin
                            shreg     <= '0;
                            oData_out <= 1'b0;
                            oLoading  <= 1'b0;
                            oDone     <= 1'b1;
                            state     <= DONE;
                        end else begin
                            shreg     <= shreg << 1;
                            oData_out <= shreg[NBITS-2];
                        end
                    end
                end
                DONE: begin
                    // A start seen here is dropped; the next accept is in IDLE.
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
